// File: rtl/clock_mode_controller.sv
// Mode sequencer for the alarm clock: RUN tick cascade, ADJUST field editing,
// alarm triggering with ring timeout and button silencing.
module clock_mode_controller #(
  parameter int unsigned ALARM_SECS = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_btn_c,
  input  logic       i_btn_l,
  input  logic       i_btn_r,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  input  logic       i_sec_is_max,
  input  logic       i_min_is_max,
  input  logic       i_alarm_match,
  output logic       o_sec_en,
  output logic       o_sec_clr,
  output logic       o_min_en,
  output logic       o_min_dec,
  output logic       o_hr_en,
  output logic       o_hr_dec,
  output logic       o_amin_en,
  output logic       o_amin_dec,
  output logic       o_ahr_en,
  output logic       o_ahr_dec,
  output logic       o_adj_mode,
  output logic [3:0] o_field_led,
  output logic       o_alarm_ring
);

  typedef enum logic {S_RUN, S_ADJ} state_t;

  typedef struct packed {
    logic sec_en;
    logic sec_clr;
    logic min_en;
    logic min_dec;
    logic hr_en;
    logic hr_dec;
    logic amin_en;
    logic amin_dec;
    logic ahr_en;
    logic ahr_dec;
  } strb_t;

  localparam logic [7:0] RING_MAX = 8'(ALARM_SECS);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_field, w_field_nxt;
  logic       r_fired, w_fired_nxt;
  logic       r_ring, w_ring_nxt;
  logic [7:0] r_ring_cnt, w_ring_cnt_nxt;
  strb_t      r_strb, w_strb;
  logic       r_adj_mode;
  logic [3:0] r_field_led, w_field_led;
  logic       w_any_btn;
  logic       w_consume;
  logic       w_dec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_RUN;
      r_field     <= 2'd0;
      r_fired     <= 1'b0;
      r_ring      <= 1'b0;
      r_ring_cnt  <= 8'd0;
      r_strb      <= '0;
      r_adj_mode  <= 1'b0;
      r_field_led <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_field     <= w_field_nxt;
      r_fired     <= w_fired_nxt;
      r_ring      <= w_ring_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_strb      <= w_strb;
      r_adj_mode  <= (w_state_nxt == S_ADJ);
      r_field_led <= w_field_led;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_field_nxt    = r_field;
    w_fired_nxt    = r_fired;
    w_ring_nxt     = r_ring;
    w_ring_cnt_nxt = r_ring_cnt;
    w_strb         = '0;
    w_any_btn      = i_btn_c | i_btn_l | i_btn_r | i_btn_u | i_btn_d;
    w_consume      = r_ring & w_any_btn;
    // btn_u outranks btn_d, so direction is down only when u is absent
    w_dec          = ~i_btn_u;

    if (r_state == S_RUN && i_tick_1hz) begin
      w_strb.sec_en = 1'b1;
      w_strb.min_en = i_sec_is_max;
      w_strb.hr_en  = i_sec_is_max & i_min_is_max;
    end

    if (!w_consume) begin
      if (i_btn_c) begin
        if (r_state == S_RUN) begin
          w_state_nxt = S_ADJ;
          w_field_nxt = 2'd0;
        end else begin
          w_state_nxt    = S_RUN;
          w_strb.sec_clr = 1'b1;
        end
      end else if (r_state == S_ADJ) begin
        if (i_btn_l) begin
          w_field_nxt = r_field - 2'd1;
        end else if (i_btn_r) begin
          w_field_nxt = r_field + 2'd1;
        end else if (i_btn_u || i_btn_d) begin
          case (r_field)
            2'd0: begin w_strb.min_en  = 1'b1; w_strb.min_dec  = w_dec; end
            2'd1: begin w_strb.hr_en   = 1'b1; w_strb.hr_dec   = w_dec; end
            2'd2: begin w_strb.amin_en = 1'b1; w_strb.amin_dec = w_dec; end
            default: begin w_strb.ahr_en = 1'b1; w_strb.ahr_dec = w_dec; end
          endcase
        end
      end
    end

    if (r_ring) begin
      if (w_any_btn || r_ring_cnt == RING_MAX) w_ring_nxt = 1'b0;
      if (i_tick_1hz && r_ring_cnt < RING_MAX) w_ring_cnt_nxt = r_ring_cnt + 8'd1;
    end

    // fired blocks re-triggering until the match goes away
    if (!i_alarm_match) begin
      w_fired_nxt = 1'b0;
    end else if (r_state == S_ADJ) begin
      w_fired_nxt = 1'b1;
    end else if (!r_fired) begin
      w_fired_nxt    = 1'b1;
      w_ring_nxt     = 1'b1;
      w_ring_cnt_nxt = 8'd0;
    end

    w_field_led = (w_state_nxt == S_ADJ) ? (4'b0001 << w_field_nxt) : 4'b0000;
  end

  assign o_sec_en     = r_strb.sec_en;
  assign o_sec_clr    = r_strb.sec_clr;
  assign o_min_en     = r_strb.min_en;
  assign o_min_dec    = r_strb.min_dec;
  assign o_hr_en      = r_strb.hr_en;
  assign o_hr_dec     = r_strb.hr_dec;
  assign o_amin_en    = r_strb.amin_en;
  assign o_amin_dec   = r_strb.amin_dec;
  assign o_ahr_en     = r_strb.ahr_en;
  assign o_ahr_dec    = r_strb.ahr_dec;
  assign o_adj_mode   = r_adj_mode;
  assign o_field_led  = r_field_led;
  assign o_alarm_ring = r_ring;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: per-cycle comparison against a
// behavioural model plus hand-computed literal checks.
module tb_clock_mode_controller;

  localparam int N = 60;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] B_C  = 6'b100000;
  localparam logic [5:0] B_L  = 6'b010000;
  localparam logic [5:0] B_R  = 6'b001000;
  localparam logic [5:0] B_U  = 6'b000100;
  localparam logic [5:0] B_D  = 6'b000010;
  localparam logic [5:0] TICK = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, bc = 1'b0, bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic smax = 1'b0, mmax = 1'b0, match = 1'b0;

  logic sec_en, sec_clr, min_en, min_dec, hr_en, hr_dec;
  logic amin_en, amin_dec, ahr_en, ahr_dec, adj_mode, alarm_ring;
  logic [3:0] field_led;

  clock_mode_controller #(.ALARM_SECS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick_1hz(tick),
    .i_btn_c(bc), .i_btn_l(bl), .i_btn_r(br), .i_btn_u(bu), .i_btn_d(bd),
    .i_sec_is_max(smax), .i_min_is_max(mmax), .i_alarm_match(match),
    .o_sec_en(sec_en), .o_sec_clr(sec_clr), .o_min_en(min_en), .o_min_dec(min_dec),
    .o_hr_en(hr_en), .o_hr_dec(hr_dec), .o_amin_en(amin_en), .o_amin_dec(amin_dec),
    .o_ahr_en(ahr_en), .o_ahr_dec(ahr_dec), .o_adj_mode(adj_mode),
    .o_field_led(field_led), .o_alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  // bit order: sec_en sec_clr min_en min_dec hr_en hr_dec amin_en amin_dec
  //            ahr_en ahr_dec adj_mode field_led[3:0] alarm_ring
  logic [15:0] dut_out;
  assign dut_out = {sec_en, sec_clr, min_en, min_dec, hr_en, hr_dec, amin_en, amin_dec,
                    ahr_en, ahr_dec, adj_mode, field_led, alarm_ring};

  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
  endtask

  // Behavioural model: mode as bool, field as int, ring tracked as tick count.
  logic [15:0] exp_out = '0;
  bit md, fired, ring;
  int fld, rt, b;
  bit nmd, nfired, nring, consumed;
  int nfld, nrt;
  logic [9:0] s;

  always @(posedge clk) begin
    s = '0;
    if (rst) begin
      md = 0; fld = 0; fired = 0; ring = 0; rt = 0;
    end else begin
      b = bc ? 1 : bl ? 2 : br ? 3 : bu ? 4 : bd ? 5 : 0;
      consumed = ring && (b != 0);
      nmd = md; nfld = fld; nfired = fired; nring = ring; nrt = rt;
      if (!md && tick) begin
        s[9] = 1'b1;
        s[7] = smax;
        s[5] = smax && mmax;
      end
      if (!consumed) begin
        if (b == 1) begin
          if (!md) begin nmd = 1; nfld = 0; end
          else begin nmd = 0; s[8] = 1'b1; end
        end else if (md) begin
          if (b == 2) nfld = (fld + 3) % 4;
          else if (b == 3) nfld = (fld + 1) % 4;
          else if (b >= 4) begin
            s[7 - 2 * fld] = 1'b1;
            s[6 - 2 * fld] = (b == 5);
          end
        end
      end
      if (ring) begin
        if (b != 0 || rt == N) nring = 0;
        if (tick && rt < N) nrt = rt + 1;
      end
      if (!match) nfired = 0;
      else if (md) nfired = 1;
      else if (!fired) begin nfired = 1; nring = 1; nrt = 0; end
      md = nmd; fld = nfld; fired = nfired; ring = nring; rt = nrt;
    end
    exp_out = {s, 1'(md), md ? 4'(1 << fld) : 4'b0000, 1'(ring)};
  end

  always @(negedge clk) if (chk_en) chk("cycle", dut_out, exp_out);

  task automatic step(input logic [5:0] v);
    {bc, bl, br, bu, bd, tick} = v;
    @(posedge clk);
    #1;
    {bc, bl, br, bu, bd, tick} = IDLE;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_all_zero", dut_out, 16'h0000);
    rst = 1'b0;
    chk_en = 1'b1;

    // RUN ticks, flags low
    for (int i = 0; i < 3; i++) begin
      step(TICK);
      chk("tick_sec_only", {15'b0, sec_en} | {min_en, hr_en, 14'b0}, 16'h0001);
      step(IDLE);
      chk("tick_one_cycle", {15'b0, sec_en}, 16'h0000);
    end

    // cascade
    smax = 1'b1; mmax = 1'b1;
    step(TICK);
    chk("cascade_all", {13'b0, sec_en, min_en, hr_en}, 16'h0007);
    mmax = 1'b0;
    step(TICK);
    chk("cascade_sec_min", {13'b0, sec_en, min_en, hr_en}, 16'h0006);
    smax = 1'b0;
    step(IDLE);

    // ADJUST navigation and edits
    step(B_C);  chk("adj_enter", {11'b0, adj_mode, field_led}, 16'h0011);
    step(B_R);  chk("field_r1", {12'b0, field_led}, 16'h0002);
    step(B_R);  chk("field_r2", {12'b0, field_led}, 16'h0004);
    step(B_D);  chk("amin_down", {14'b0, amin_en, amin_dec}, 16'h0003);
    step(B_L);  chk("field_l", {12'b0, field_led}, 16'h0002);
    step(B_U);  chk("hr_up", {14'b0, hr_en, hr_dec}, 16'h0002);
    step(TICK); chk("adj_tick_ignored", {15'b0, sec_en}, 16'h0000);

    // c beats u
    step(B_C | B_U);
    chk("exit_clr", {12'b0, adj_mode, sec_clr, hr_en, min_en}, 16'h0004);
    step(IDLE);

    // alarm ring and timeout
    match = 1'b1;
    step(IDLE); chk("ring_start", {15'b0, alarm_ring}, 16'h0001);
    for (int i = 0; i < N; i++) begin
      step(TICK);
      step(IDLE);
    end
    chk("ring_timeout", {15'b0, alarm_ring}, 16'h0000);
    for (int i = 0; i < 3; i++) step(IDLE);
    chk("no_rering", {15'b0, alarm_ring}, 16'h0000);
    match = 1'b0; step(IDLE);
    match = 1'b1; step(IDLE);
    chk("rering", {15'b0, alarm_ring}, 16'h0001);

    // silence by button, cascade continues while ringing
    smax = 1'b1;
    step(TICK); chk("ring_cascade", {14'b0, min_en, alarm_ring}, 16'h0003);
    smax = 1'b0;
    step(B_C);  chk("silence", {14'b0, adj_mode, alarm_ring}, 16'h0000);

    // reset mid-ring
    match = 1'b0; step(IDLE);
    match = 1'b1; step(IDLE);
    chk("ring_again", {15'b0, alarm_ring}, 16'h0001);
    rst = 1'b1; match = 1'b0;
    step(IDLE);
    chk("reset_mid_ring", dut_out, 16'h0000);
    rst = 1'b0;

    // match while adjusting must not ring after exit; field wrap at 0
    step(B_C);
    step(B_L);  chk("field_wrap", {12'b0, field_led}, 16'h0008);
    step(B_U);  chk("ahr_up", {14'b0, ahr_en, ahr_dec}, 16'h0002);
    match = 1'b1;
    step(IDLE); step(IDLE);
    step(B_C);  chk("exit_on_match", {14'b0, sec_clr, alarm_ring}, 16'h0002);
    step(IDLE); step(IDLE);
    chk("no_ring_after_adj", {14'b0, adj_mode, alarm_ring}, 16'h0000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Central sequencer for the alarm clock's counter datapath: seconds, minutes and hours chains for time, plus minutes and hours chains for the alarm.
- In RUN it converts the 1 Hz tick into cascaded per-counter enables.
- In ADJUST it routes debounced button pulses to increment/decrement strobes on one selected field.
- It also owns alarm triggering, the ring timeout and silencing.

Parameters:
- ALARM_SECS, 60, number of tick_1hz pulses the alarm rings before auto-silencing (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick_1hz  input  1  single-cycle pulse, once per second
- btn_c, btn_l, btn_r, btn_u, btn_d  input  1 each  debounced single-cycle button pulses
- sec_is_max  input  1  seconds counter currently 59
- min_is_max  input  1  minutes counter currently 59
- alarm_match  input  1  clock hh:mm equals alarm hh:mm
- sec_en  output  1  seconds counter count strobe
- sec_clr  output  1  seconds counter clear strobe
- min_en, min_dec  output  1 each  clock minutes count strobe / direction (1 = down)
- hr_en, hr_dec  output  1 each  clock hours count strobe / direction
- amin_en, amin_dec  output  1 each  alarm minutes count strobe / direction
- ahr_en, ahr_dec  output  1 each  alarm hours count strobe / direction
- adj_mode  output  1  1 while in ADJUST
- field_led  output  4  one-hot selected field in ADJUST ([0] clk min, [1] clk hr, [2] alm min, [3] alm hr); 0 in RUN
- alarm_ring  output  1  alarm sounding

Behaviour:
- Register and reset rules
  - All outputs are registered.
  - Every strobe is one cycle wide and asserts the cycle after the sampled input event (latency 1).
  - Reset: state=RUN, field=0, every output 0, fired=0, ring_cnt=0. Reset dominates all other inputs in the same cycle, including mid-ring and mid-adjust.
- State RUN
  - On tick_1hz: sec_en=1.
  - If sec_is_max is also 1: min_en=1.
  - If sec_is_max and min_is_max are both 1: hr_en=1.
  - The *_dec outputs are 0 in RUN.
  - The max flags are sampled in the tick cycle and reflect the pre-increment counter values.
  - Hour wrap belongs to the counter, not this block.
- RUN -> ADJUST
  - Trigger: btn_c while not ringing. Field resets to 0 (clk min).
  - The tick strobe for the transition cycle is still issued, because state was RUN when sampled.
- State ADJUST
  - Ticks are ignored: no sec_en, min_en or hr_en from ticks.
  - btn_r: field = field+1 mod 4. btn_l: field = field-1 mod 4.
  - btn_u: en strobe of the selected field, dec=0. btn_d: en strobe of the selected field, dec=1.
  - The dec signal is valid in the same cycle as its en.
- ADJUST -> RUN
  - Trigger: btn_c.
  - Issue sec_clr=1 for one cycle so seconds restart at 00.
- Button priority
  - Multiple buttons in one cycle: only the highest-priority one acts.
  - Priority order: c > l > r > u > d.
- Alarm
  - fired flag is cleared whenever alarm_match=0.
  - In ADJUST, fired is set whenever alarm_match=1, so leaving ADJUST onto a matching time does not ring.
  - In RUN, alarm_match=1 and fired=0: alarm_ring=1 next cycle, fired=1, ring_cnt=0.
- Ringing
  - Each tick increments ring_cnt.
  - When ring_cnt reaches ALARM_SECS, alarm_ring clears the following cycle.
  - Any button pulse while ringing clears alarm_ring next cycle. That button is consumed: no mode, field or strobe effect.
  - Time keeps running during ringing; tick cascade is unaffected.
- Width rules
  - field is 2 bits and wraps.
  - ring_cnt is 8 bits and saturates at ALARM_SECS.

Test Plan:
1. Reset, then 3 ticks with flags 0 -> sec_en pulses exactly 3, each 1 cycle after its tick; min_en, hr_en stay 0; all outputs 0 immediately after reset.
2. RUN tick with sec_is_max=1, min_is_max=1 -> sec_en, min_en, hr_en all 1 in the same cycle; with only sec_is_max=1 -> hr_en stays 0.
3. btn_c, btn_r, btn_r, btn_d, btn_l, btn_u -> adj_mode=1; field_led 0001 -> 0010 -> 0100; amin_en=1 with amin_dec=1; field_led back to 0010; hr_en=1 with hr_dec=0; ticks during ADJUST give no sec_en.
4. btn_c and btn_u in the same cycle while in ADJUST -> RUN entered, sec_clr=1, no hr_en or min_en.
5. alarm_match rises in RUN -> alarm_ring=1 next cycle; after 60 ticks -> 0. Hold alarm_match high -> no re-ring. Drop then raise alarm_match -> rings again.
6. Ring active, btn_c -> alarm_ring=0 next cycle, adj_mode stays 0. Assert rst mid-ring -> all outputs 0 next cycle. Match present while in ADJUST, then btn_c to RUN -> no ring.
